// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes on both sides.
// Operands are turned into magnitudes; the product sign is applied once at the end.
module seq_multiplier #(
    parameter int WIDTH_A        = 10,
    parameter int WIDTH_B        = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    input  logic                       is_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] c,
    output logic                       busy
);

    localparam int WIDTH_C = WIDTH_A + WIDTH_B;
    localparam int N       = WIDTH_B / BITS_PER_CYCLE;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH_B % BITS_PER_CYCLE) != 0) begin : g_bpc_check
            $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH_B exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH_C-1:0]   r_mcand;
    logic [WIDTH_B-1:0]   r_mplier;
    logic [WIDTH_C-1:0]   r_acc;
    logic [WIDTH_C-1:0]   r_c;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH_A-1:0]   w_mag_a;
    logic [WIDTH_B-1:0]   w_mag_b;
    logic [WIDTH_C-1:0]   w_pp;
    logic [WIDTH_C-1:0]   w_acc_next;
    logic [WIDTH_C-1:0]   w_result;
    logic                 w_last;
    logic                 w_accept;

    // Magnitude of a two's-complement value; the most-negative value maps to 2^(W-1) unsigned.
    function automatic logic [WIDTH_A-1:0] mag_a(input logic [WIDTH_A-1:0] v, input logic sgn);
        if (sgn && v[WIDTH_A-1]) begin
            mag_a = ~v + WIDTH_A'(1);
        end else begin
            mag_a = v;
        end
    endfunction

    function automatic logic [WIDTH_B-1:0] mag_b(input logic [WIDTH_B-1:0] v, input logic sgn);
        if (sgn && v[WIDTH_B-1]) begin
            mag_b = ~v + WIDTH_B'(1);
        end else begin
            mag_b = v;
        end
    endfunction

    assign w_mag_a    = mag_a(a, is_signed);
    assign w_mag_b    = mag_b(b, is_signed);
    assign w_accept   = in_valid && r_in_ready;
    // The multiplicand is pre-shifted each cycle, so the partial product needs no variable shift.
    assign w_pp       = r_mcand * WIDTH_C'(r_mplier[BITS_PER_CYCLE-1:0]);
    assign w_acc_next = r_acc + w_pp;
    assign w_last     = (r_cnt == CNT_W'(N - 1));
    assign w_result   = r_neg ? (~w_acc_next + WIDTH_C'(1)) : w_acc_next;

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= WIDTH_C'(0);
            r_mplier    <= WIDTH_B'(0);
            r_acc       <= WIDTH_C'(0);
            r_c         <= WIDTH_C'(0);
            r_cnt       <= CNT_W'(0);
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand    <= WIDTH_C'(w_mag_a);
                        r_mplier   <= w_mag_b;
                        r_neg      <= is_signed && (a[WIDTH_A-1] ^ b[WIDTH_B-1]);
                        r_acc      <= WIDTH_C'(0);
                        r_cnt      <= CNT_W'(0);
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_c         <= w_result;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a default instance (1 bit/cycle) for directed vectors and a
// 4 bits/cycle instance for randomised traffic, both checked every cycle against a transaction model.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0, in_valid0, in_ready0, s0, out_valid0, out_ready0, busy0;
    logic [9:0]  a0;
    logic [7:0]  b0;
    logic [17:0] c0;
    logic        rst_n1, in_valid1, in_ready1, s1, out_valid1, out_ready1, busy1;
    logic [9:0]  a1;
    logic [7:0]  b1;
    logic [17:0] c1;

    logic        len0, len1;
    logic [17:0] lit0, lit1;
    logic        finish_req;
    int          tmo;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          m_busy [2];
    bit          m_len  [2];
    int          m_acc  [2];
    logic [17:0] m_prod [2];
    logic [17:0] m_last [2];
    logic [17:0] m_lit  [2];

    seq_multiplier #(.WIDTH_A(10), .WIDTH_B(8), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .is_signed(s0), .out_valid(out_valid0), .out_ready(out_ready0),
        .c(c0), .busy(busy0)
    );

    seq_multiplier #(.WIDTH_A(10), .WIDTH_B(8), .BITS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .is_signed(s1), .out_valid(out_valid1), .out_ready(out_ready1),
        .c(c1), .busy(busy1)
    );

    // Exact product from integer arithmetic, reduced to 18 bits.
    function automatic logic [17:0] ref_mul(input logic [9:0] x, input logic [7:0] y, input logic s);
        longint px, py, p;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        return p[17:0];
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d: got 0x%0h, expected 0x%0h", nm, g, cyc, act, exp);
        end
    endtask

    // Transaction-level model: idle -> busy on accept, valid N cycles later, idle after handshake.
    task automatic mon(input int g, input int n, input logic rst, input logic iv,
                       input logic [9:0] ai, input logic [7:0] bi, input logic si,
                       input logic ordy, input logic irdy, input logic ov,
                       input logic [17:0] cv, input logic bsy, input logic len,
                       input logic [17:0] lc);
        logic        ov_e;
        logic [17:0] c_e;
        if (!rst) begin
            chk("rst_in_ready", g, 32'(irdy), 32'(1'b1));
            chk("rst_out_valid", g, 32'(ov), 32'(1'b0));
            chk("rst_busy", g, 32'(bsy), 32'(1'b0));
            chk("rst_c", g, 32'(cv), 32'(18'h0));
            m_busy[g] = 1'b0;
            m_last[g] = 18'h0;
        end else begin
            ov_e = m_busy[g] && (cyc >= m_acc[g] + n);
            c_e  = ov_e ? m_prod[g] : m_last[g];
            chk("in_ready", g, 32'(irdy), 32'(!m_busy[g]));
            chk("busy", g, 32'(bsy), 32'(m_busy[g]));
            chk("out_valid", g, 32'(ov), 32'(ov_e));
            chk("c", g, 32'(cv), 32'(c_e));
            if (ov_e && (cyc == m_acc[g] + n) && m_len[g]) begin
                chk("c_literal", g, 32'(cv), 32'(m_lit[g]));
            end
            if (!m_busy[g] && iv) begin
                m_busy[g] = 1'b1;
                m_acc[g]  = cyc + 1;
                m_prod[g] = ref_mul(ai, bi, si);
                m_len[g]  = len;
                m_lit[g]  = lc;
                if (len) begin
                    chk("model_literal", g, 32'(m_prod[g]), 32'(lc));
                end
            end else if (ov_e && ordy) begin
                m_busy[g] = 1'b0;
                m_last[g] = m_prod[g];
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (finish_req) begin
            chk("timeouts", 0, 32'(tmo), 32'(0));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (cyc > 30000) begin
            failures++;
            $display("FAIL watchdog: cycle budget exhausted at cyc=%0d", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else begin
            mon(0, 8, rst_n0, in_valid0, a0, b0, s0, out_ready0, in_ready0, out_valid0, c0, busy0, len0, lit0);
            mon(1, 2, rst_n1, in_valid1, a1, b1, s1, out_ready1, in_ready1, out_valid1, c1, busy1, len1, lit1);
        end
    end

    task automatic put0(input logic [9:0] a, input logic [7:0] b, input logic s, input logic [17:0] lit);
        int   k;
        logic ac;
        a0 = a; b0 = b; s0 = s; lit0 = lit; len0 = 1'b1; in_valid0 = 1'b1;
        k = 0;
        do begin
            ac = in_ready0;
            @(posedge clk); #1;
            k++;
        end while (!ac && k < 100);
        if (!ac) tmo++;
    endtask

    task automatic wait_ov0();
        int k;
        k = 0;
        while (!out_valid0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid0) tmo++;
    endtask

    task automatic xact0(input logic [9:0] a, input logic [7:0] b, input logic s, input logic [17:0] lit);
        put0(a, b, s, lit);
        in_valid0 = 1'b0;
        wait_ov0();
        @(posedge clk); #1;
    endtask

    initial begin
        int   k;
        logic a_now, h_now, hs;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b1; out_ready1 = 1'b1;
        a0 = 10'h0; b0 = 8'h0; s0 = 1'b0; a1 = 10'h0; b1 = 8'h0; s1 = 1'b0;
        len0 = 1'b0; len1 = 1'b0; lit0 = 18'h0; lit1 = 18'h0;
        finish_req = 1'b0; tmo = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(posedge clk); #1;

        xact0(10'h3FF, 8'hFF, 1'b0, 18'h3FB01);
        xact0(10'h200, 8'h80, 1'b1, 18'h10000);
        xact0(10'h3FF, 8'h05, 1'b1, 18'h3FFFB);
        xact0(10'd7,   8'hFD, 1'b1, 18'h3FFEB);

        // Backpressure: a second pair waits while the first product is stalled.
        out_ready0 = 1'b0;
        put0(10'd25, 8'd9, 1'b0, 18'h000E1);
        a0 = 10'h3FD; b0 = 8'h7F; s0 = 1'b1; lit0 = 18'h3FE83;
        wait_ov0();
        repeat (5) @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        put0(10'h3FD, 8'h7F, 1'b1, 18'h3FE83);
        in_valid0 = 1'b0;
        wait_ov0();
        @(posedge clk); #1;

        // Asynchronous reset during the third calculation cycle.
        put0(10'd100, 8'd200, 1'b0, 18'h04E20);
        in_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n0 = 1'b1;
        xact0(10'd3, 8'd4, 1'b0, 18'd12);

        // Back-to-back zero operand with in_valid held high.
        a0 = 10'h0; b0 = 8'hAA; s0 = 1'b0; lit0 = 18'h0; len0 = 1'b1; in_valid0 = 1'b1;
        repeat (30) @(posedge clk);
        #1 in_valid0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Four-bits-per-cycle instance: two pinned vectors, then random pairs with random stalls.
        for (int i = 0; i < 200; i++) begin
            if (i == 0) begin
                a1 = 10'h200; b1 = 8'h80; s1 = 1'b1; len1 = 1'b1; lit1 = 18'h10000;
            end else if (i == 1) begin
                a1 = 10'h3FF; b1 = 8'hFF; s1 = 1'b0; len1 = 1'b1; lit1 = 18'h3FB01;
            end else begin
                a1 = 10'($urandom); b1 = 8'($urandom); s1 = 1'($urandom_range(0, 1));
                len1 = 1'b0; lit1 = 18'h0;
            end
            in_valid1 = 1'b1;
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 300) begin
                out_ready1 = ($urandom_range(0, 3) != 0);
                a_now = in_valid1 && in_ready1;
                h_now = out_valid1 && out_ready1;
                @(posedge clk); #1;
                k++;
                if (a_now) in_valid1 = 1'b0;
                if (h_now) hs = 1'b1;
            end
            if (!hs) tmo++;
        end
        repeat (4) @(posedge clk);
        #1 finish_req = 1'b1;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-add multiplier that computes c = a*b over several cycles, replacing the single-cycle multiplier.
- Accepts operands via valid/ready, selects signed or unsigned per transaction, retires BITS_PER_CYCLE multiplier bits per cycle.
- Presents the result via valid/ready with backpressure.
- Sits between operand-producing datapath stages and downstream accumulators.

Parameters:
- WIDTH_A, 10, bits in operand a.
- WIDTH_B, 8, bits in operand b.
- BITS_PER_CYCLE, 1, multiplier bits of b consumed per CALC cycle. Must divide WIDTH_B exactly; elaboration error otherwise.
- WIDTH_C, WIDTH_A+WIDTH_B, product width (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, is_signed valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH_A  multiplicand
- b  input  WIDTH_B  multiplier
- is_signed  input  1  1: a, b are two's complement; 0: unsigned
- out_valid  output  1  c holds a valid product
- out_ready  input  1  consumer accepts c
- c  output  WIDTH_C  product
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset is asynchronous on rst_n low and dominates all inputs:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, c=0, internal accumulator/counters=0.
- N = WIDTH_B/BITS_PER_CYCLE.
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state==IDLE), registered-state derived; no combinational path from out_ready.
  - IDLE -> CALC on the edge where in_valid && in_ready.
    - Latch a, b and is_signed.
    - If is_signed: store |a| and |b|, and neg = a_msb XOR b_msb. If not signed: neg = 0.
    - Clear accumulator; iteration counter = 0.
  - CALC: each edge adds (|a| * next BITS_PER_CYCLE LSBs of |b|) shifted by counter*BITS_PER_CYCLE into the accumulator, then increments the counter.
    - After the N-th CALC edge: state = DONE.
    - On that same edge, c = neg ? two's-complement negate(acc) : acc, truncated to WIDTH_C, and out_valid = 1.
  - DONE: out_valid=1; c, out_valid and in_ready remain stable while out_ready=0, for any number of cycles.
    - DONE -> IDLE on the edge where out_valid && out_ready. out_valid=0 and in_ready=1 after that edge.
- Latency: acceptance edge k gives out_valid high after edge k+N.
- Throughput with out_ready tied high: one product per N+2 cycles.
- c holds the last product after the handshake until the next product is loaded; it is 0 only after reset.
- in_valid while in_ready=0 is ignored. The producer holds a, b and is_signed until acceptance.
- Arithmetic:
  - Unsigned result equals the exact a*b (fits WIDTH_C).
  - Signed result equals the exact two's-complement product in WIDTH_C, including the most-negative cases. Example: a=-2^(WIDTH_A-1), b=-2^(WIDTH_B-1) gives +2^(WIDTH_C-2).
  - Magnitudes use WIDTH_A/WIDTH_B-bit unsigned storage; the most-negative magnitude fits unsigned.
- A zero operand still takes the full N cycles; there is no early termination.
- rst_n asserted mid-CALC or mid-DONE aborts the operation; no stale out_valid after release.
- busy = (state != IDLE).

Test Plan:
1. Defaults, is_signed=0, a=10'h3FF, b=8'hFF, out_ready=1 -> c=18'h3FB01 (260865), out_valid rises exactly 8 cycles after acceptance, held 1 cycle, in_ready high 1 cycle later.
2. is_signed=1: a=10'h200 (-512), b=8'h80 (-128) -> c=18'h10000; then a=10'h3FF (-1), b=8'h05 -> c=18'h3FFFB; then a=10'd7, b=8'hFD (-3) -> c=18'h3FFEB.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with a new pair -> c, out_valid stable; in_ready=0; new pair not accepted until the cycle after out_ready=1 handshake; second product correct.
4. Reset mid-operation: accept a=100, b=200; drop rst_n during the 3rd CALC cycle -> out_valid=0, busy=0, c=0, in_ready=1 immediately (async); after release, a=3, b=4 -> c=12 with normal latency.
5. BITS_PER_CYCLE=4 (N=2), 200 random unsigned and signed pairs with random out_ready stalls, compared with reference model -> zero mismatches; acceptance-to-out_valid latency always 2.
6. Back-to-back with out_ready=1 and in_valid always high -> accepted every N+2 cycles; a=0, b=8'hAA -> c=0 after the full N cycles.
